// File: rtl/decoder3x8_seq.sv
// decoder3x8_seq: buffers {idle, code} beats in a small FIFO and replays each
// buffered code as a one-hot output held for HOLD cycles; counts idle beats.
module decoder3x8_seq #(
    parameter int unsigned HOLD  = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_idle,
    input  logic [2:0] in_code,
    output logic [7:0] out_onehot,
    output logic       out_valid,
    output logic [2:0] out_code,
    output logic       busy,
    output logic [7:0] idle_cnt
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [7:0]  HOLD_M1 = 8'(HOLD - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [2:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [0:0]  r_state;
    logic [7:0]  r_cnt;
    logic [7:0]  r_onehot;
    logic        r_valid;
    logic [2:0]  r_code;
    logic [7:0]  r_idle_cnt;

    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic [2:0]  w_head;

    // Wrap bit differs with equal index bits: pointers a full lap apart.
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign in_ready = ~w_full;
    assign w_accept = in_valid & ~w_full;
    assign w_push   = w_accept & ~in_idle;
    assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
    assign w_pop    = ~w_empty & ((r_state == S_IDLE) || (r_cnt == 8'd0));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= in_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if (w_accept && in_idle && (r_idle_cnt != 8'hFF)) begin
            r_idle_cnt <= r_idle_cnt + 8'd1;
        end
    end

    // A pop at the end of a hold reloads directly, so codes play back-to-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_onehot <= '0;
            r_valid  <= 1'b0;
            r_code   <= '0;
        end else if (w_pop) begin
            r_state  <= S_HOLD;
            r_cnt    <= HOLD_M1;
            r_onehot <= 8'd1 << w_head;
            r_valid  <= 1'b1;
            r_code   <= w_head;
        end else if (r_state == S_HOLD) begin
            if (r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end else begin
                r_state  <= S_IDLE;
                r_onehot <= '0;
                r_valid  <= 1'b0;
                r_code   <= '0;
            end
        end
    end

    assign out_onehot = r_onehot;
    assign out_valid  = r_valid;
    assign out_code   = r_code;
    assign busy       = r_valid | ~w_empty;
    assign idle_cnt   = r_idle_cnt;

endmodule

// File: tb/tb_decoder3x8_seq.sv
// Self-checking bench for decoder3x8_seq: directed table, multi-cycle corner
// sequences and random traffic against a schedule-based reference model.
module tb_decoder3x8_seq;

    localparam int unsigned HOLD_T  = 4;
    localparam int unsigned DEPTH_T = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid, in_idle, in_ready, out_valid, busy;
    logic [2:0] in_code, out_code;
    logic [7:0] out_onehot, idle_cnt;

    logic       v1, i1, r1, ov1, b1;
    logic [2:0] c1, oc1;
    logic [7:0] oh1, ic1;

    always #5 clk = ~clk;

    decoder3x8_seq #(.HOLD(4), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_idle(in_idle), .in_code(in_code), .out_onehot(out_onehot),
        .out_valid(out_valid), .out_code(out_code), .busy(busy), .idle_cnt(idle_cnt)
    );

    decoder3x8_seq #(.HOLD(1), .DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1),
        .in_idle(i1), .in_code(c1), .out_onehot(oh1),
        .out_valid(ov1), .out_code(oc1), .busy(b1), .idle_cnt(ic1)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: every accepted code gets a start edge
    // max(accept+1, end of previous code) and plays for HOLD_T edges.
    typedef struct { int code; int start; } sched_t;
    sched_t sched[$];
    int n, last_end, m_idle;

    function automatic void m_clear();
        sched.delete();
        n = 0;
        last_end = 0;
        m_idle = 0;
    endfunction

    function automatic int m_occ();
        int c = 0;
        foreach (sched[i]) if (sched[i].start > n) c++;
        return c;
    endfunction

    function automatic int m_play();
        foreach (sched[i])
            if (sched[i].start <= n && n < sched[i].start + int'(HOLD_T)) return sched[i].code;
        return -1;
    endfunction

    task automatic m_check(input string tag);
        int p, occ;
        p = m_play();
        occ = m_occ();
        check({tag, ".onehot"}, out_onehot, (p < 0) ? 0 : (1 << p));
        check({tag, ".valid"}, out_valid, (p < 0) ? 0 : 1);
        check({tag, ".code"}, out_code, (p < 0) ? 0 : p);
        check({tag, ".busy"}, busy, (p >= 0 || occ > 0) ? 1 : 0);
        check({tag, ".ready"}, in_ready, (occ < int'(DEPTH_T)) ? 1 : 0);
        check({tag, ".idle_cnt"}, idle_cnt, m_idle);
    endtask

    task automatic step(input logic v, input logic idl, input logic [2:0] c, output logic acc);
        int s;
        in_valid = v;
        in_idle  = idl;
        in_code  = c;
        acc = v && (m_occ() < int'(DEPTH_T));
        @(posedge clk);
        n++;
        if (acc) begin
            if (idl) begin
                if (m_idle < 255) m_idle++;
            end else begin
                s = (n + 1 > last_end) ? n + 1 : last_end;
                sched.push_back('{int'(c), s});
                last_end = s + int'(HOLD_T);
            end
        end
        while (sched.size() > 0 && sched[0].start + int'(HOLD_T) <= n) void'(sched.pop_front());
        @(negedge clk);
        m_check("model");
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_idle = 1'b0; in_code = '0;
        v1 = 1'b0; i1 = 1'b0; c1 = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.onehot", out_onehot, 0);
        check("rst.valid", out_valid, 0);
        check("rst.code", out_code, 0);
        check("rst.busy", busy, 0);
        check("rst.idle_cnt", idle_cnt, 0);
        check("rst.ready", in_ready, 1);
        rst_n = 1'b1;
        m_clear();
    endtask

    typedef struct packed {
        logic       v;
        logic [2:0] code;
        logic [7:0] oh;
        logic       ov;
        logic [2:0] oc;
        logic       bz;
        logic       rdy;
    } vec_t;

    vec_t tbl [20];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc, saw_low;
        logic [7:0] e1 [5];
        logic       dv1 [5];
        logic [2:0] dc1 [5];

        // single beat 5, then back-to-back 7,0,3; row i = state after edge i+1
        tbl[0] = '{1'b1, 3'd5, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1};
        for (int i = 1; i <= 4; i++) tbl[i] = '{1'b0, 3'd0, 8'h20, 1'b1, 3'd5, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 3'd7, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 3'd0, 8'h80, 1'b1, 3'd7, 1'b1, 1'b1};
        tbl[8] = '{1'b1, 3'd3, 8'h80, 1'b1, 3'd7, 1'b1, 1'b1};
        for (int i = 9; i <= 10; i++) tbl[i] = '{1'b0, 3'd0, 8'h80, 1'b1, 3'd7, 1'b1, 1'b1};
        for (int i = 11; i <= 14; i++) tbl[i] = '{1'b0, 3'd0, 8'h01, 1'b1, 3'd0, 1'b1, 1'b1};
        for (int i = 15; i <= 18; i++) tbl[i] = '{1'b0, 3'd0, 8'h08, 1'b1, 3'd3, 1'b1, 1'b1};
        tbl[19] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1};

        do_reset();
        for (int i = 0; i < 20; i++) begin
            in_valid = tbl[i].v;
            in_idle  = 1'b0;
            in_code  = tbl[i].code;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("tbl%0d.onehot", i), out_onehot, tbl[i].oh);
            check($sformatf("tbl%0d.valid", i), out_valid, tbl[i].ov);
            check($sformatf("tbl%0d.code", i), out_code, tbl[i].oc);
            check($sformatf("tbl%0d.busy", i), busy, tbl[i].bz);
            check($sformatf("tbl%0d.ready", i), in_ready, tbl[i].rdy);
        end

        // fill: source holds each beat until accepted
        do_reset();
        saw_low = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            int tries = 0;
            acc = 1'b0;
            while (!acc && tries < 100) begin
                step(1'b1, 1'b0, c[2:0], acc);
                if (!in_ready) saw_low = 1'b1;
                tries++;
            end
            if (!acc) check("fill.accept_timeout", 0, 1);
        end
        repeat (40) step(1'b0, 1'b0, 3'd0, acc);
        check("fill.ready_deasserted", saw_low, 1);

        // idle beats with don't-care code
        do_reset();
        repeat (3) step(1'b1, 1'b1, 3'bxxx, acc);
        check("idle3.cnt", idle_cnt, 3);
        check("idle3.busy", busy, 0);
        repeat (300) step(1'b1, 1'b1, 3'bxxx, acc);
        check("idle300.cnt", idle_cnt, 255);

        // random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom % 2), 1'($urandom % 4 == 0), 3'($urandom), acc);
        end
        repeat (40) step(1'b0, 1'b0, 3'd0, acc);

        // reset in the 2nd hold cycle of code 6 with two entries queued
        do_reset();
        step(1'b1, 1'b0, 3'd6, acc);
        step(1'b1, 1'b0, 3'd1, acc);
        step(1'b1, 1'b0, 3'd2, acc);
        check("midrst.pre_onehot", out_onehot, 8'h40);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst.onehot", out_onehot, 0);
        check("midrst.valid", out_valid, 0);
        check("midrst.busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_clear();
        repeat (8) step(1'b0, 1'b0, 3'd0, acc);
        step(1'b1, 1'b0, 3'd2, acc);
        step(1'b0, 1'b0, 3'd0, acc);
        check("midrst.new_code", out_onehot, 8'h04);
        repeat (6) step(1'b0, 1'b0, 3'd0, acc);

        // HOLD=1 instance: beats 4,4,2 on consecutive edges
        do_reset();
        dv1 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        dc1 = '{3'd4, 3'd4, 3'd2, 3'd0, 3'd0};
        e1  = '{8'h00, 8'h10, 8'h10, 8'h04, 8'h00};
        for (int k = 0; k < 5; k++) begin
            v1 = dv1[k];
            c1 = dc1[k];
            i1 = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("hold1.%0d.onehot", k), oh1, e1[k]);
            check($sformatf("hold1.%0d.ready", k), r1, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
